// File: rtl/contador_cm_pkg.sv
// contador_cm_pkg: FSM state codes, default tick divider and BCD helpers shared by contador_cm_n.
package contador_cm_pkg;

    typedef enum logic [2:0] {
        INICIAL = 3'b000,
        MEDE    = 3'b001,
        FIM     = 3'b010,
        ERRO    = 3'b011
    } estado_t;

    localparam int TICK_DIV_PADRAO = 2941;

    function automatic logic [31:0] to_bcd(input int valor);
        logic [31:0] r;
        int x;
        r = '0;
        x = valor;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        logic [31:0] r;
        logic vai;
        r = v;
        vai = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (vai) begin
                r[4*i +: 4] = (v[4*i +: 4] == 4'd9) ? 4'd0 : v[4*i +: 4] + 4'd1;
                vai = (v[4*i +: 4] == 4'd9);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_bcd_n.sv
// contador_bcd_n: NDIG-digit cascaded decade counter with synchronous clear and count enable.
module contador_bcd_n #(
    parameter int NDIG = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zera,
    input  logic              conta,
    output logic [4*NDIG-1:0] valor
);

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        logic [3:0] dig;
        logic       inc;
        // a digit advances only when every lower digit is about to wrap
        always_comb begin
            inc = conta;
            for (int i = 0; i < d; i++) inc = inc && (valor[4*i +: 4] == 4'd9);
        end
        always_ff @(posedge clock or negedge reset)
            if (!reset) dig <= '0;
            else if (zera) dig <= '0;
            else if (inc) dig <= (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        assign valor[4*d +: 4] = dig;
    end

endmodule

// File: rtl/contador_cm_n.sv
// contador_cm_n: echo pulse width to centimetres in BCD, with overflow flag and pronto handshake.
// Define CONTADOR_CM_ARRED_EN to round the result to the nearest centimetre.
module contador_cm_n
    import contador_cm_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_PADRAO,
    parameter int NDIG        = 3,
    parameter int MAX_CM      = 400,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              habilita,
    input  logic              pulso,
    output logic [4*NDIG-1:0] medida,
    output logic              pronto,
    output logic              erro,
    output logic              ocupado,
    output logic [2:0]        db_estado
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [4*NDIG-1:0] MAX_BCD = (4*NDIG)'(to_bcd(MAX_CM));

    estado_t estado, prox;
    logic [SYNC_STAGES-1:0] sinc;
    logic [SYNC_STAGES:0]   vld;
    logic                   pulso_s, pulso_d, borda, inicia, fim_tick, conta;
    logic [TW-1:0]          tick_cnt;
    logic [4*NDIG-1:0]      cm, resultado;

    assign pulso_s  = sinc[SYNC_STAGES-1];
    // edges only count once pulso_d holds a genuine sample, so a pulse already high at reset release is ignored
    assign borda    = vld[SYNC_STAGES] && pulso_s && !pulso_d;
    assign inicia   = (estado == INICIAL) && borda && habilita;
    assign fim_tick = pulso_s && (tick_cnt == TW'(TICK_DIV - 1));
    assign conta    = (estado == MEDE) && fim_tick && (cm != MAX_BCD);

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            sinc    <= '0;
            vld     <= '0;
            pulso_d <= 1'b0;
        end else begin
            sinc    <= {sinc[SYNC_STAGES-2:0], pulso};
            vld     <= {vld[SYNC_STAGES-1:0], 1'b1};
            pulso_d <= pulso_s;
        end

    always_ff @(posedge clock or negedge reset)
        if (!reset) estado <= INICIAL;
        else estado <= prox;

    always_comb begin
        prox = estado;
        case (estado)
            INICIAL: prox = inicia ? MEDE : INICIAL;
            MEDE:    prox = !pulso_s ? FIM : (fim_tick && cm == MAX_BCD) ? ERRO : MEDE;
            ERRO:    prox = pulso_s ? ERRO : FIM;
            FIM:     prox = INICIAL;
            default: prox = INICIAL;
        endcase
    end

    contador_bcd_n #(.NDIG(NDIG)) u_bcd (
        .clock (clock),
        .reset (reset),
        .zera  (inicia),
        .conta (conta),
        .valor (cm)
    );

`ifdef CONTADOR_CM_ARRED_EN
    logic [4*NDIG-1:0] cm_inc;
    assign cm_inc    = (4*NDIG)'(bcd_inc(32'(cm)));
    assign resultado = (tick_cnt >= TW'(TICK_DIV / 2) && cm != MAX_BCD) ? cm_inc : cm;
`else
    assign resultado = cm;
`endif

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            tick_cnt <= '0;
            medida   <= '0;
            erro     <= 1'b0;
        end else begin
            if (inicia) begin
                tick_cnt <= TW'(1);
                erro     <= 1'b0;
            end else if (estado == MEDE && pulso_s) begin
                tick_cnt <= fim_tick ? '0 : tick_cnt + TW'(1);
            end
            if (estado == MEDE && !pulso_s) medida <= resultado;
            if (estado == ERRO && !pulso_s) begin
                medida <= MAX_BCD;
                erro   <= 1'b1;
            end
        end

    assign pronto    = (estado == FIM);
    assign ocupado   = (estado == MEDE) || (estado == ERRO);
    assign db_estado = estado;

endmodule

// File: tb/tb_contador_cm_n.sv
// tb_contador_cm_n: randomized and directed checks of contador_cm_n against a pulse-width arithmetic model.
module tb_contador_cm_n;

    logic clock = 0, reset = 0, habilita = 0, pulso = 0;
    logic [11:0] medida, medida5;
    logic pronto, pronto5, erro, erro5, ocupado, ocupado5;
    logic [2:0] db_estado, db_estado5;
    int errors = 0, checks = 0;

    always #5 clock = ~clock;

    contador_cm_n #(.TICK_DIV(4), .NDIG(3), .MAX_CM(400), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .pulso(pulso),
        .medida(medida), .pronto(pronto), .erro(erro), .ocupado(ocupado), .db_estado(db_estado));

    contador_cm_n #(.TICK_DIV(4), .NDIG(3), .MAX_CM(5), .SYNC_STAGES(2)) dut5 (
        .clock(clock), .reset(reset), .habilita(habilita), .pulso(pulso),
        .medida(medida5), .pronto(pronto5), .erro(erro5), .ocupado(ocupado5), .db_estado(db_estado5));

    typedef struct {
        int lat; int np; int first3;
        logic [11:0] m; logic e; logic [2:0] st1; logic occ;
    } obs_t;
    obs_t o, o5;

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // distance in cm for a pulse of n clock cycles at 4 cycles/cm
    function automatic int ref_cm(input int n, input int mx);
        int q;
        q = n / 4;
        if (q > mx) return mx;
`ifdef CONTADOR_CM_ARRED_EN
        if (n % 4 >= 2 && q < mx) q++;
`endif
        return q;
    endfunction

    function automatic logic ref_err(input int n, input int mx);
        return (n / 4) > mx;
    endfunction

    task automatic run_pulse(input int n, input logic hab, input int hab_off);
        o  = '{lat: 0, np: 0, first3: 0, m: '0, e: 0, st1: '0, occ: 0};
        o5 = '{lat: 0, np: 0, first3: 0, m: '0, e: 0, st1: '0, occ: 0};
        habilita = hab;
        pulso = 1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clock); #1;
            if (ocupado) o.occ = 1;
            if (ocupado5) o5.occ = 1;
            if (db_estado5 == 3'd3 && o5.first3 == 0) o5.first3 = i;
            if (i == hab_off) habilita = 0;
        end
        pulso = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock); #1;
            if (k == 1) begin o.st1 = db_estado; o5.st1 = db_estado5; end
            if (ocupado) o.occ = 1;
            if (ocupado5) o5.occ = 1;
            if (pronto) begin
                o.np++;
                if (o.lat == 0) begin o.lat = k; o.m = medida; o.e = erro; end
            end
            if (pronto5) begin
                o5.np++;
                if (o5.lat == 0) begin o5.lat = k; o5.m = medida5; o5.e = erro5; end
            end
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if ({medida, pronto, erro, ocupado, db_estado} !== 18'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {medida, pronto, erro, ocupado, db_estado}); end
        checks++; if ({medida5, pronto5, erro5, ocupado5, db_estado5} !== 18'd0) begin
            errors++; $display("FAIL reset_outputs5: got %h expected 0", {medida5, pronto5, erro5, ocupado5, db_estado5}); end
        @(posedge clock); #1;
        reset = 1;
        repeat (5) begin @(posedge clock); #1; end
    endtask

    task automatic test_basic;
        run_pulse(40, 1, 0);
        checks++; if (o.lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", o.lat); end
        checks++; if (o.np !== 1) begin errors++; $display("FAIL basic_pronto_count: got %0d expected 1", o.np); end
        checks++; if (o.m !== 12'h010) begin errors++; $display("FAIL basic_medida: got %h expected 010", o.m); end
        checks++; if (o.e !== 1'b0) begin errors++; $display("FAIL basic_erro: got %b expected 0", o.e); end
        checks++; if (o.st1 !== 3'd1) begin errors++; $display("FAIL basic_state_mede: got %0d expected 1", o.st1); end
        checks++; if (o.occ !== 1'b1) begin errors++; $display("FAIL basic_ocupado: got %b expected 1", o.occ); end
    endtask

    task automatic test_rounding;
        logic [11:0] exp42;
`ifdef CONTADOR_CM_ARRED_EN
        exp42 = 12'h011;
`else
        exp42 = 12'h010;
`endif
        run_pulse(42, 1, 0);
        checks++; if (o.m !== exp42) begin errors++; $display("FAIL round_42: got %h expected %h", o.m, exp42); end
        run_pulse(41, 1, 0);
        checks++; if (o.m !== 12'h010) begin errors++; $display("FAIL round_41: got %h expected 010", o.m); end
        checks++; if (o.e !== 1'b0) begin errors++; $display("FAIL round_41_erro: got %b expected 0", o.e); end
    endtask

    task automatic test_overflow;
        run_pulse(30, 1, 0);
        checks++; if (o5.first3 !== 26) begin errors++; $display("FAIL ovf_erro_entry: got %0d expected 26", o5.first3); end
        checks++; if (o5.st1 !== 3'd3) begin errors++; $display("FAIL ovf_state_erro: got %0d expected 3", o5.st1); end
        checks++; if (o5.m !== 12'h005) begin errors++; $display("FAIL ovf_medida: got %h expected 005", o5.m); end
        checks++; if (o5.e !== 1'b1) begin errors++; $display("FAIL ovf_erro: got %b expected 1", o5.e); end
        checks++; if (o5.np !== 1 || o5.lat !== 3) begin
            errors++; $display("FAIL ovf_pronto: got np=%0d lat=%0d expected np=1 lat=3", o5.np, o5.lat); end
        checks++; if (o.m !== 12'h007) begin errors++; $display("FAIL ovf_wide_medida: got %h expected 007", o.m); end
        run_pulse(8, 1, 0);
        checks++; if (o5.m !== 12'h002 || o5.e !== 1'b0) begin
            errors++; $display("FAIL ovf_recover: got %h/%b expected 002/0", o5.m, o5.e); end
    endtask

    task automatic test_reset_release;
        int np, busy, bad_state;
        np = 0; busy = 0; bad_state = 0;
        reset = 0; pulso = 1; habilita = 1;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1;
        repeat (10) begin
            @(posedge clock); #1;
            if (pronto) np++;
            if (ocupado) busy++;
            if (db_estado != 3'd0) bad_state++;
        end
        pulso = 0;
        repeat (6) begin
            @(posedge clock); #1;
            if (pronto) np++;
        end
        checks++; if (bad_state !== 0 || busy !== 0) begin
            errors++; $display("FAIL release_state: got bad=%0d busy=%0d expected 0/0", bad_state, busy); end
        checks++; if (np !== 0) begin errors++; $display("FAIL release_pronto: got %0d expected 0", np); end
        run_pulse(8, 1, 0);
        checks++; if (o.m !== 12'h002) begin errors++; $display("FAIL release_next: got %h expected 002", o.m); end
    endtask

    task automatic test_reset_mid;
        int np;
        np = 0;
        habilita = 1; pulso = 1;
        repeat (20) begin @(posedge clock); #1; end
        checks++; if (db_estado !== 3'd1) begin errors++; $display("FAIL mid_pre_state: got %0d expected 1", db_estado); end
        #2 reset = 0;
        #1;
        checks++; if ({medida, pronto, erro, ocupado, db_estado} !== 18'd0) begin
            errors++; $display("FAIL mid_async_clear: got %h expected 0", {medida, pronto, erro, ocupado, db_estado}); end
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1;
        repeat (18) begin @(posedge clock); #1; if (pronto || ocupado) np++; end
        pulso = 0;
        repeat (12) begin @(posedge clock); #1; if (pronto || ocupado) np++; end
        checks++; if (np !== 0) begin errors++; $display("FAIL mid_no_pronto: got %0d expected 0", np); end
    endtask

    task automatic test_habilita;
        run_pulse(12, 1, 0);
        run_pulse(20, 0, 0);
        habilita = 1;
        checks++; if (o.np !== 0 || o.occ !== 1'b0) begin
            errors++; $display("FAIL hab_off: got np=%0d occ=%b expected 0/0", o.np, o.occ); end
        checks++; if (medida !== 12'h003) begin errors++; $display("FAIL hab_hold: got %h expected 003", medida); end
        run_pulse(16, 1, 5);
        habilita = 1;
        checks++; if (o.m !== 12'h004 || o.np !== 1) begin
            errors++; $display("FAIL hab_drop_mid: got %h np=%0d expected 004 np=1", o.m, o.np); end
    endtask

    task automatic test_random;
        logic [11:0] em, em5;
        logic ee, ee5;
        int n;
        logic hab;
        em = medida; em5 = medida5; ee = erro; ee5 = erro5;
        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(1, 60);
            hab = ($urandom_range(0, 3) != 0);
            run_pulse(n, hab, 0);
            habilita = 1;
            if (hab) begin
                em = bcd(ref_cm(n, 400)); ee = ref_err(n, 400);
                em5 = bcd(ref_cm(n, 5));  ee5 = ref_err(n, 5);
                checks++; if (o.lat !== 3 || o.np !== 1) begin
                    errors++; $display("FAIL rnd_pronto n=%0d: got lat=%0d np=%0d expected 3/1", n, o.lat, o.np); end
                checks++; if (o5.lat !== 3 || o5.np !== 1) begin
                    errors++; $display("FAIL rnd_pronto5 n=%0d: got lat=%0d np=%0d expected 3/1", n, o5.lat, o5.np); end
            end else begin
                checks++; if (o.np !== 0 || o5.np !== 0) begin
                    errors++; $display("FAIL rnd_disabled n=%0d: got np=%0d/%0d expected 0", n, o.np, o5.np); end
            end
            checks++; if (medida !== em || erro !== ee) begin
                errors++; $display("FAIL rnd_medida n=%0d: got %h/%b expected %h/%b", n, medida, erro, em, ee); end
            checks++; if (medida5 !== em5 || erro5 !== ee5) begin
                errors++; $display("FAIL rnd_medida5 n=%0d: got %h/%b expected %h/%b", n, medida5, erro5, em5, ee5); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_rounding;
        test_overflow;
        test_reset_release;
        test_reset_mid;
        test_habilita;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
